// File: rtl/nios2_bus_output.sv
// Avalon-MM slave that queues CPU-written bytes in a small FIFO and presents
// them to fabric logic over a valid/ready stream, with status and last-written readback.
module nios2_bus_output #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]         count_q, count_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic                  overflow_q, overflow_d;
   logic [DATA_WIDTH-1:0] last_q, last_d;
   logic [31:0]           readdata_q, readdata_d;

   logic wr_strobe, push_req, push, pop, flush, ovf_clr, full, empty;

   always_comb begin
      wr_strobe = chipselect && !write_n;
      empty     = (count_q == '0);
      // Full comes from the registered count, so a same-cycle pop cannot make room.
      full      = (count_q == FULL_CNT);
      push_req  = wr_strobe && (address == 2'd0);
      push      = push_req && !full;
      pop       = !empty && out_ready;
      flush     = wr_strobe && (address == 2'd2) && writedata[0];
      ovf_clr   = wr_strobe && (address == 2'd1) && writedata[10];

      out_valid = !empty;
      out_port  = empty ? '0 : mem_q[rd_ptr_q];
   end

   always_comb begin
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      overflow_d = overflow_q;
      last_d     = last_q;

      if (push_req && full) overflow_d = 1'b1;
      if (ovf_clr)          overflow_d = 1'b0;
      if (push)             last_d     = writedata[DATA_WIDTH-1:0];

      if (flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         2'd0: readdata_d[DATA_WIDTH-1:0] = out_port;
         2'd1: begin
            readdata_d[CW-1:0] = count_q;
            readdata_d[8]      = empty;
            readdata_d[9]      = full;
            readdata_d[10]     = overflow_q;
         end
         2'd3:    readdata_d[DATA_WIDTH-1:0] = last_q;
         default: readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         overflow_q <= 1'b0;
         last_q     <= '0;
         readdata_q <= '0;
      end else begin
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         overflow_q <= overflow_d;
         last_q     <= last_d;
         readdata_q <= readdata_d;
      end
   end

   // Storage is left unreset: entries are only visible while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= writedata[DATA_WIDTH-1:0];
   end

   assign readdata = readdata_q;

endmodule

// File: tb/tb_nios2_bus_output.sv
// Directed bench for nios2_bus_output: register access, FIFO ordering,
// overflow, flush and asynchronous reset behaviour.
module tb_nios2_bus_output;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;
   logic        out_valid;
   logic        out_ready;

   int unsigned total = 0;
   int unsigned bad   = 0;

   nios2_bus_output #(.DATA_WIDTH(8), .DEPTH(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      step();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = a;
      step();
      chk(tag, readdata, exp);
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      out_ready  = 1'b0;
      repeat (3) step();
      chk("rst_readdata", readdata, 32'h0);
      reset_n = 1'b1;

      // Reset state
      rd("rst_status", 2'd1, 32'h0000_0100);
      chk("rst_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_port", {24'b0, out_port}, 32'h0);

      // Single push, no fall-through, readback paths
      chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'hFFFF_FFA5;
      chk("pre_push_valid", {31'b0, out_valid}, 32'h0);
      step();
      chipselect = 1'b0; write_n = 1'b1;
      chk("push_valid", {31'b0, out_valid}, 32'h1);
      chk("push_port", {24'b0, out_port}, 32'hA5);
      rd("last_a5", 2'd3, 32'h0000_00A5);
      rd("status_c1", 2'd1, 32'h0000_0001);
      rd("addr0_head", 2'd0, 32'h0000_00A5);
      rd("addr2_zero", 2'd2, 32'h0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("pop_a5_valid", {31'b0, out_valid}, 32'h0);

      // Fill past full, then drain in order
      for (int i = 1; i <= 5; i++) wr(2'd0, 32'(i));
      chk("full_hold_port", {24'b0, out_port}, 32'h01);
      rd("status_full_ovf", 2'd1, 32'h0000_0604);
      out_ready = 1'b1;
      chk("drain_01", {24'b0, out_port}, 32'h01);
      step();
      chk("drain_02", {24'b0, out_port}, 32'h02);
      step();
      chk("drain_03", {24'b0, out_port}, 32'h03);
      step();
      chk("drain_04", {24'b0, out_port}, 32'h04);
      step();
      chk("drain_done_valid", {31'b0, out_valid}, 32'h0);
      chk("drain_done_port", {24'b0, out_port}, 32'h0);
      out_ready = 1'b0;
      rd("status_empty_ovf", 2'd1, 32'h0000_0500);
      rd("last_after_drop", 2'd3, 32'h0000_0004);

      // Overflow clear only via bit 10
      wr(2'd1, 32'hFFFF_FBFF);
      rd("ovf_not_cleared", 2'd1, 32'h0000_0500);
      wr(2'd1, 32'h0000_0400);
      rd("ovf_cleared", 2'd1, 32'h0000_0100);

      // Simultaneous push/pop at count 2 and at count 4
      wr(2'd0, 32'h10);
      wr(2'd0, 32'h11);
      out_ready = 1'b1;
      wr(2'd0, 32'h12);
      out_ready = 1'b0;
      chk("pp2_head", {24'b0, out_port}, 32'h11);
      rd("pp2_status", 2'd1, 32'h0000_0002);
      wr(2'd0, 32'h13);
      wr(2'd0, 32'h14);
      rd("pp4_pre_status", 2'd1, 32'h0000_0204);
      out_ready = 1'b1;
      wr(2'd0, 32'h15);
      out_ready = 1'b0;
      chk("pp4_head", {24'b0, out_port}, 32'h12);
      rd("pp4_status", 2'd1, 32'h0000_0403);
      rd("pp4_last", 2'd3, 32'h0000_0014);

      // Flush at count 3
      wr(2'd2, 32'h1);
      chk("flush_valid", {31'b0, out_valid}, 32'h0);
      chk("flush_port", {24'b0, out_port}, 32'h0);
      rd("flush_status", 2'd1, 32'h0000_0500);
      rd("flush_last", 2'd3, 32'h0000_0014);
      wr(2'd1, 32'h0000_0400);
      rd("flush_ovf_clr", 2'd1, 32'h0000_0100);
      wr(2'd0, 32'h20);
      chk("post_flush_head", {24'b0, out_port}, 32'h20);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("post_flush_pop", {31'b0, out_valid}, 32'h0);

      // Address 3 writes are ignored
      wr(2'd3, 32'hFF);
      rd("addr3_ignored", 2'd3, 32'h0000_0020);
      rd("addr3_status", 2'd1, 32'h0000_0100);

      // Asynchronous reset mid-drain
      wr(2'd0, 32'h31);
      wr(2'd0, 32'h32);
      wr(2'd0, 32'h33);
      address   = 2'd3;
      out_ready = 1'b1;
      step();
      chk("mid_drain_head", {24'b0, out_port}, 32'h32);
      chk("mid_drain_rd", readdata, 32'h0000_0033);
      #2 reset_n = 1'b0;
      #1;
      chk("async_valid", {31'b0, out_valid}, 32'h0);
      chk("async_port", {24'b0, out_port}, 32'h0);
      chk("async_readdata", readdata, 32'h0);
      step();
      out_ready = 1'b0;
      reset_n   = 1'b1;
      rd("post_rst_status", 2'd1, 32'h0000_0100);
      rd("post_rst_last", 2'd3, 32'h0);
      wr(2'd0, 32'h44);
      chk("post_rst_valid", {31'b0, out_valid}, 32'h1);
      chk("post_rst_head", {24'b0, out_port}, 32'h44);
      rd("post_rst_count", 2'd1, 32'h0000_0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nios2_bus_output.md
NIOS2_BUS_OUTPUT -- requirements
Module: nios2_bus_output

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, width of the output data byte.
REQ-002 SHALL provide parameter DEPTH, default 4, number of FIFO entries; must be a power of two, at least 2.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL provide port address, input, 2, Avalon-MM slave register select.
REQ-006 SHALL provide port chipselect, input, 1, Avalon-MM slave select.
REQ-007 SHALL provide port write_n, input, 1, active-low write strobe.
REQ-008 SHALL provide port writedata, input, 32, CPU write data.
REQ-009 SHALL provide port readdata, output, 32, registered CPU read data.
REQ-010 SHALL provide port out_port, output, DATA_WIDTH, FIFO head byte to fabric game logic.
REQ-011 SHALL provide port out_valid, output, 1, out_port holds a valid byte.
REQ-012 SHALL provide port out_ready, input, 1, fabric accepts the byte.

Function
REQ-013 SHALL define the write strobe as chipselect=1 and write_n=0; no waitrequest, so every write completes in one cycle.
REQ-014 SHALL, on a write to address 0 while the FIFO is not full, push writedata[DATA_WIDTH-1:0] at the tail and copy it to the last-written register.
REQ-015 SHALL, on a write to address 0 while full, drop the data, leave the FIFO unchanged and set the sticky overflow flag.
REQ-016 SHALL evaluate full from the registered count before any same-cycle pop, so a push to a full FIFO is dropped even when a pop occurs in that cycle.
REQ-017 SHALL, on a write to address 1 with writedata[10]=1, clear overflow (write-1-to-clear); all other bits SHALL be ignored.
REQ-018 SHALL, on a write to address 2 with writedata[0]=1, flush the FIFO: count, read pointer and write pointer go to 0 and out_valid deasserts next cycle; overflow and the last-written register SHALL remain unchanged.
REQ-019 SHALL ignore writes to address 3.
REQ-020 SHALL drive out_valid=1 exactly when count>0, and drive out_port with the head entry when valid and 0 when empty.
REQ-021 SHALL pop the head when out_valid=1 and out_ready=1, and SHALL keep out_port stable while out_valid=1 and out_ready=0.
REQ-022 SHALL have no fall-through: a byte pushed into an empty FIFO is visible on out_port/out_valid one cycle after the write cycle.
REQ-023 SHALL keep count unchanged on a simultaneous accepted push and pop, and SHALL never overflow or underflow count.
REQ-024 SHALL wrap read and write pointers modulo DEPTH; the count is clog2(DEPTH)+1 bits wide.
REQ-025 SHALL register readdata every cycle regardless of chipselect, with one-cycle read latency, from the following sources:
- address 0: out_port, zero-extended.
- address 1: status, bits [clog2(DEPTH):0]=count, bit 8=empty, bit 9=full, bit 10=overflow, all other bits 0.
- address 2: 0.
- address 3: last-written register, zero-extended.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously force to 0: readdata, count, both pointers, overflow, last-written register, out_port and out_valid.
REQ-027 SHALL discard FIFO contents on reset applied mid-operation; after release the FIFO is empty and status reads 0x100.
REQ-028 SHALL NOT require FIFO storage entries to be reset; they are unobservable while empty.

Verification
REQ-029 SHALL cover: reset, then read address 1 -> readdata=0x00000100, out_valid=0, out_port=0.
REQ-030 SHALL cover: write 0xA5 to addr 0 with out_ready=0 -> next cycle out_valid=1, out_port=0xA5, addr 3 reads 0xA5, status count=1.
REQ-031 SHALL cover: with out_ready=0, write 0x01..0x05 to addr 0 -> status=0x604 (count 4, full, overflow); drain with out_ready=1 -> out_port 0x01,0x02,0x03,0x04 on consecutive cycles, then out_valid=0.
REQ-032 SHALL cover: with count=2, push and pop in the same cycle -> count stays 2 and order is preserved. With count=4, push and pop in the same cycle -> the push is dropped, count=3 and overflow=1.
REQ-033 SHALL cover: with count=3, write 0x1 to addr 2 -> next cycle out_valid=0 and count=0. Then write 0x400 to addr 1 -> overflow=0.
REQ-034 SHALL cover: assert reset_n=0 asynchronously mid-drain (between clock edges) -> all outputs are 0 immediately; after release, the first push appears as the head entry.
